// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard for the in-order issue stage.
// Tracks outstanding writes to the general and float register files, holds
// issue while any source or the destination has a write in flight, and
// provides a drain sequence that waits for every outstanding write to retire.
//
//   state | meaning
//   IDLE  | normal operation, issue allowed when hazards are clear
//   DRAIN | issue blocked, waiting for both pending vectors to empty
//   DONE  | scoreboard empty, drain_done pulses, back to IDLE
module reg_scoreboard #(
  parameter int WB_PORTS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       issue_valid,
  output logic       issue_ready,
  input  logic [4:0] src_num [3],
  input  logic       src_general [3],
  input  logic       src_float [3],
  input  logic       dst_general,
  input  logic       dst_float,
  input  logic [4:0] dst_num,
  input  logic       wb_valid [WB_PORTS],
  input  logic       wb_float [WB_PORTS],
  input  logic [4:0] wb_num [WB_PORTS],
  input  logic       drain_req,
  output logic       drain_done,
  output logic [6:0] pending_count
);

  typedef enum logic [1:0] {S_IDLE, S_DRAIN, S_DONE} state_t;

  state_t      state, state_next;
  logic [31:0] gpend, fpend;
  logic [31:0] gpend_next, fpend_next;
  logic [31:0] clr_g, clr_f;
  logic [31:0] set_g, set_f;
  logic [31:0] gbusy, fbusy;
  logic        hazard;
  logic        fire;

  // Writeback clear masks; several ports naming one register collapse to one bit.
  always_comb begin
    clr_g = '0;
    clr_f = '0;
    for (int p = 0; p < WB_PORTS; p++) begin
      if (wb_valid[p]) begin
        if (wb_float[p]) clr_f[wb_num[p]] = 1'b1;
        else             clr_g[wb_num[p]] = 1'b1;
      end
    end
  end

  // A register retiring this cycle already counts as free (zero-cycle bypass).
  assign gbusy = gpend & ~clr_g;
  assign fbusy = fpend & ~clr_f;

  // Source and destination hazard check; a dual-file destination is treated as general.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (src_general[i] && gbusy[src_num[i]]) hazard = 1'b1;
      if (src_float[i]   && fbusy[src_num[i]]) hazard = 1'b1;
    end
    if (dst_general) begin
      if (gbusy[dst_num]) hazard = 1'b1;
    end else if (dst_float) begin
      if (fbusy[dst_num]) hazard = 1'b1;
    end
  end

  assign issue_ready = (state == S_IDLE) && !drain_req && !hazard;
  assign fire        = issue_valid && issue_ready;

  // Pending vector update: issue set is applied after writeback clear so set wins.
  always_comb begin
    set_g = '0;
    set_f = '0;
    if (fire) begin
      if (dst_general) begin
        if (dst_num != 5'd0) set_g[dst_num] = 1'b1;
      end else if (dst_float) begin
        set_f[dst_num] = 1'b1;
      end
    end
    gpend_next    = (gpend & ~clr_g) | set_g;
    gpend_next[0] = 1'b0;
    fpend_next    = (fpend & ~clr_f) | set_f;
  end

  // Pending vector registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpend <= '0;
      fpend <= '0;
    end else begin
      gpend <= gpend_next;
      fpend <= fpend_next;
    end
  end

  // Drain sequencer next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (drain_req) state_next = S_DRAIN;
      S_DRAIN: if (gpend == '0 && fpend == '0) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Drain state and registered completion pulse, high exactly while in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      drain_done <= 1'b0;
    end else begin
      state      <= state_next;
      drain_done <= (state_next == S_DONE);
    end
  end

  // Population count of the registered pending vectors.
  always_comb begin
    pending_count = '0;
    for (int i = 0; i < 32; i++) begin
      pending_count = pending_count + 7'(gpend[i]) + 7'(fpend[i]);
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed bench for reg_scoreboard: hazards, bypass, r0 handling, WAW,
// drain sequencing and asynchronous reset.
module tb_reg_scoreboard;

  logic       clk;
  logic       reset;
  logic       issue_valid;
  logic       issue_ready;
  logic [4:0] src_num [3];
  logic       src_general [3];
  logic       src_float [3];
  logic       dst_general;
  logic       dst_float;
  logic [4:0] dst_num;
  logic       wb_valid [2];
  logic       wb_float [2];
  logic [4:0] wb_num [2];
  logic       drain_req;
  logic       drain_done;
  logic [6:0] pending_count;

  int n_checks = 0;
  int n_fail   = 0;

  reg_scoreboard #(.WB_PORTS(2)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .src_num(src_num), .src_general(src_general), .src_float(src_float),
    .dst_general(dst_general), .dst_float(dst_float), .dst_num(dst_num),
    .wb_valid(wb_valid), .wb_float(wb_float), .wb_num(wb_num),
    .drain_req(drain_req), .drain_done(drain_done),
    .pending_count(pending_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    issue_valid = 1'b0;
    dst_general = 1'b0;
    dst_float   = 1'b0;
    dst_num     = 5'd0;
    drain_req   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      src_num[i] = 5'd0; src_general[i] = 1'b0; src_float[i] = 1'b0;
    end
    for (int p = 0; p < 2; p++) begin
      wb_valid[p] = 1'b0; wb_float[p] = 1'b0; wb_num[p] = 5'd0;
    end
  endtask

  // Advance to just after the next rising edge with all inputs idle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic issue_dst(input logic fl, input logic [4:0] n);
    issue_valid = 1'b1;
    dst_general = !fl;
    dst_float   = fl;
    dst_num     = n;
  endtask

  task automatic wb(input int p, input logic fl, input logic [4:0] n);
    wb_valid[p] = 1'b1;
    wb_float[p] = fl;
    wb_num[p]   = n;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    reset = 1'b1;
    #12;
    #1 check("reset_count", pending_count, 0);
    check("reset_done", drain_done, 0);
    check("reset_ready", issue_ready, 1);
    reset = 1'b0;

    // RAW on general r5, released by same-cycle writeback.
    next_cycle();
    issue_dst(1'b0, 5'd5);
    #1 check("r5_issue_ready", issue_ready, 1);
    next_cycle();
    issue_valid = 1'b1; src_num[0] = 5'd5; src_general[0] = 1'b1;
    #1 check("r5_stall_c1", issue_ready, 0);
    check("r5_count_c1", pending_count, 1);
    next_cycle();
    issue_valid = 1'b1; src_num[0] = 5'd5; src_general[0] = 1'b1;
    #1 check("r5_stall_c2", issue_ready, 0);
    next_cycle();
    issue_valid = 1'b1; src_num[0] = 5'd5; src_general[0] = 1'b1;
    wb(0, 1'b0, 5'd5);
    #1 check("r5_bypass_c3", issue_ready, 1);
    check("r5_count_c3", pending_count, 1);
    next_cycle();
    #1 check("r5_count_c4", pending_count, 0);

    // Float f5 does not alias general r5.
    issue_dst(1'b1, 5'd5);
    next_cycle();
    issue_valid = 1'b1; src_num[1] = 5'd5; src_general[1] = 1'b1;
    #1 check("f5_gen_src_ok", issue_ready, 1);
    src_general[1] = 1'b0; src_float[1] = 1'b1;
    #1 check("f5_src_stall", issue_ready, 0);
    wb(0, 1'b0, 5'd5);
    #1 check("f5_gen_wb_no_clear", issue_ready, 0);
    wb(1, 1'b1, 5'd5);
    #1 check("f5_float_wb_bypass", issue_ready, 1);
    issue_valid = 1'b0;
    next_cycle();
    #1 check("f5_count_cleared", pending_count, 0);

    // r0 is never pending and never stalls.
    issue_dst(1'b0, 5'd0);
    next_cycle();
    #1 check("r0_count", pending_count, 0);
    issue_valid = 1'b1; src_num[2] = 5'd0; src_general[2] = 1'b1;
    dst_general = 1'b1; dst_num = 5'd0;
    #1 check("r0_src_ready", issue_ready, 1);
    issue_valid = 1'b0;

    // WAW on f7, double writeback clears once.
    next_cycle();
    issue_dst(1'b1, 5'd7);
    next_cycle();
    issue_dst(1'b0, 5'd3);
    next_cycle();
    #1 check("waw_count2", pending_count, 2);
    issue_dst(1'b1, 5'd7);
    #1 check("waw_stall", issue_ready, 0);
    issue_valid = 1'b0;
    wb(0, 1'b1, 5'd7);
    wb(1, 1'b1, 5'd7);
    #1 check("waw_bypass", issue_ready, 1);
    next_cycle();
    #1 check("waw_single_clear", pending_count, 1);
    // Issue to r3 while r3 retires: set wins, count stays.
    issue_dst(1'b0, 5'd3);
    wb(0, 1'b0, 5'd3);
    #1 check("setwins_ready", issue_ready, 1);
    next_cycle();
    #1 check("setwins_count", pending_count, 1);
    wb(0, 1'b0, 5'd3);
    next_cycle();
    #1 check("setwins_cleared", pending_count, 0);

    // Empty drain: request at t, pulse at t+2 only.
    drain_req = 1'b1;
    #1 check("edrain_ready_req", issue_ready, 0);
    next_cycle();
    #1 check("edrain_done_t1", drain_done, 0);
    check("edrain_ready_t1", issue_ready, 0);
    next_cycle();
    #1 check("edrain_done_t2", drain_done, 1);
    next_cycle();
    #1 check("edrain_done_t3", drain_done, 0);
    check("edrain_ready_t3", issue_ready, 1);

    // Drain with r3, r4, f9 retiring in cycles 5, 6, 8.
    issue_dst(1'b0, 5'd3);                     // cycle 0
    next_cycle(); issue_dst(1'b0, 5'd4);       // cycle 1
    next_cycle(); issue_dst(1'b1, 5'd9);       // cycle 2
    next_cycle(); drain_req = 1'b1;            // cycle 3
    #1 check("drain_ready_c3", issue_ready, 0);
    next_cycle();                              // cycle 4
    #1 check("drain_count_c4", pending_count, 3);
    check("drain_ready_c4", issue_ready, 0);
    next_cycle(); wb(0, 1'b0, 5'd3);           // cycle 5
    next_cycle(); wb(1, 1'b0, 5'd4);           // cycle 6
    drain_req = 1'b1;
    next_cycle();                              // cycle 7
    #1 check("drain_count_c7", pending_count, 1);
    next_cycle(); wb(1, 1'b1, 5'd9);           // cycle 8
    #1 check("drain_done_c8", drain_done, 0);
    next_cycle();                              // cycle 9
    #1 check("drain_done_c9", drain_done, 0);
    check("drain_count_c9", pending_count, 0);
    next_cycle();                              // cycle 10
    issue_valid = 1'b1;
    #1 check("drain_done_c10", drain_done, 1);
    check("drain_ready_c10", issue_ready, 0);
    next_cycle();                              // cycle 11
    #1 check("drain_done_c11", drain_done, 0);
    check("drain_ready_c11", issue_ready, 1);

    // Asynchronous reset in the middle of a drain.
    issue_dst(1'b0, 5'd10);
    next_cycle(); issue_dst(1'b0, 5'd11);
    next_cycle(); issue_dst(1'b1, 5'd12);
    next_cycle(); drain_req = 1'b1;
    next_cycle();
    #1 check("rst_pre_count", pending_count, 3);
    check("rst_pre_ready", issue_ready, 0);
    #2 reset = 1'b1;
    #1 check("rst_async_count", pending_count, 0);
    check("rst_async_done", drain_done, 0);
    check("rst_async_ready", issue_ready, 1);
    next_cycle();
    reset = 1'b0;
    next_cycle();
    #1 check("rst_post_done", drain_done, 0);
    next_cycle();
    #1 check("rst_post_done2", drain_done, 0);
    check("rst_post_ready", issue_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
